// File: rtl/adder_seq_ctrl.sv
// Nibble-serial add/subtract sequencer around a shared 4-bit CLA slice.
// Operands are accepted in IDLE, processed LSB nibble first in RUN, held in DONE.
module adder4 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       c_i,
    output logic [3:0] s_o,
    output logic       c_o
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    assign c[0] = c_i;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign s_o = p ^ c[3:0];
    assign c_o = c[4];
endmodule

module adder_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] s,
    output logic                 cout,
    output logic                 ovf,
    output logic                 busy
);
    localparam int W  = 4 * NIBBLES;
    localparam int KW = $clog2(NIBBLES);
    localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  s_q, s_d;
    logic          sub_q, sub_d;
    logic          c_q, c_d;
    logic          cout_q, cout_d;
    logic          ovf_q, ovf_d;
    logic [KW-1:0] k_q, k_d;

    logic [KW+1:0] base;
    logic [3:0]    sl_a;
    logic [3:0]    sl_b;
    logic [3:0]    sl_s;
    logic          sl_c;

    assign base = {k_q, 2'b00};
    assign sl_a = a_q[base +: 4];
    assign sl_b = b_q[base +: 4] ^ {4{sub_q}};

    adder4 u_add (
        .a_i (sl_a),
        .b_i (sl_b),
        .c_i (c_q),
        .s_o (sl_s),
        .c_o (sl_c)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        sub_d   = sub_q;
        c_d     = c_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        k_d     = k_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    sub_d   = sub;
                    c_d     = sub;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                s_d[base +: 4] = sl_s;
                c_d            = sl_c;
                // k holds on the last slice so it never wraps
                if (k_q == K_LAST) begin
                    cout_d  = sl_c;
                    ovf_d   = (sl_a[3] == sl_b[3]) && (sl_s[3] != sl_a[3]);
                    state_d = DONE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            sub_q   <= 1'b0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            sub_q   <= sub_d;
            c_q     <= c_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            k_q     <= k_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign s         = s_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Directed bench for adder_seq_ctrl at NIBBLES=4.
// Expected values are hand-computed constants.
module tb_adder_seq_ctrl;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] s;
    logic        cout;
    logic        ovf;
    logic        busy;

    int checks = 0;
    int errors = 0;

    adder_seq_ctrl #(.NIBBLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands for one accept edge, then scramble the inputs.
    task automatic start_op(input logic [15:0] ta, input logic [15:0] tb,
                            input logic tsub);
        a        = ta;
        b        = tb;
        sub      = tsub;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a        = 16'hDEAD;
        b        = 16'hBEEF;
        sub      = ~tsub;
    endtask

    // Cycles from the accept edge (inclusive) until out_valid is seen.
    task automatic wait_done(output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 16'h0;
        b         = 16'h0;
        sub       = 1'b0;
        tick();
        tick();
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            errors++;
            $display("FAIL reset_ctrl: got rdy/vld/busy=%b want 100",
                     {in_ready, out_valid, busy});
        end
        checks++;
        if ({s, cout, ovf} !== 18'h0) begin
            errors++;
            $display("FAIL reset_data: got s=%h cout=%b ovf=%b want 0",
                     s, cout, ovf);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_add();
        int lat;
        out_ready = 1'b1;
        start_op(16'h1234, 16'h4321, 1'b0);
        wait_done(lat);
        checks++;
        if (lat !== 5) begin
            errors++;
            $display("FAIL add_latency: got %0d want 5", lat);
        end
        checks++;
        if ({s, cout, ovf} !== {16'h5555, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL add_result: got s=%h c=%b o=%b want 5555 0 0",
                     s, cout, ovf);
        end
    endtask

    // Entered in DONE with out_ready=1: next accept is 6 edges after the first.
    task automatic test_back_to_back();
        int lat;
        a        = 16'hFFFF;
        b        = 16'h0001;
        sub      = 1'b0;
        in_valid = 1'b1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL done_in_ready: got %b want 0", in_ready);
        end
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: got rdy=%b vld=%b want 1 0",
                     in_ready, out_valid);
        end
        tick();
        in_valid = 1'b0;
        a        = 16'h0;
        b        = 16'h0;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept: got busy=%b rdy=%b want 1 0",
                     busy, in_ready);
        end
        wait_done(lat);
        checks++;
        if (lat !== 5) begin
            errors++;
            $display("FAIL ripple_latency: got %0d want 5", lat);
        end
        checks++;
        if ({s, cout, ovf} !== {16'h0000, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL ripple_result: got s=%h c=%b o=%b want 0000 1 0",
                     s, cout, ovf);
        end
        tick();
    endtask

    task automatic test_overflow();
        int lat;
        start_op(16'h7FFF, 16'h0001, 1'b0);
        wait_done(lat);
        checks++;
        if (lat < 0 || {s, cout, ovf} !== {16'h8000, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL add_ovf: got lat=%0d s=%h c=%b o=%b want 8000 0 1",
                     lat, s, cout, ovf);
        end
        tick();
    endtask

    task automatic test_sub();
        int lat;
        start_op(16'h0005, 16'h0007, 1'b1);
        wait_done(lat);
        checks++;
        if (lat < 0 || {s, cout, ovf} !== {16'hFFFE, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL sub_borrow: got lat=%0d s=%h c=%b o=%b want FFFE 0 0",
                     lat, s, cout, ovf);
        end
        tick();
        start_op(16'h8000, 16'h0001, 1'b1);
        wait_done(lat);
        checks++;
        if (lat < 0 || {s, cout, ovf} !== {16'h7FFF, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL sub_ovf: got lat=%0d s=%h c=%b o=%b want 7FFF 1 1",
                     lat, s, cout, ovf);
        end
        tick();
    endtask

    task automatic test_backpressure();
        int lat;
        out_ready = 1'b0;
        start_op(16'h1234, 16'h0234, 1'b1);
        wait_done(lat);
        for (int i = 0; i < 10; i++) begin
            in_valid = (i == 3);
            a        = 16'h0F0F;
            b        = 16'h7777;
            sub      = 1'b0;
            tick();
            checks++;
            if (lat < 0 || out_valid !== 1'b1 || in_ready !== 1'b0 ||
                {s, cout, ovf} !== {16'h1000, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL hold_%0d: got vld=%b rdy=%b s=%h c=%b o=%b want 1 0 1000 1 0",
                         i, out_valid, in_ready, s, cout, ovf);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_release: got rdy=%b vld=%b want 1 0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        out_ready = 1'b1;
        start_op(16'hAAAA, 16'h5555, 1'b0);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b100 ||
            {s, cout, ovf} !== 18'h0) begin
            errors++;
            $display("FAIL mid_reset: got rdy/vld/busy=%b s=%h c=%b o=%b want 100 0",
                     {in_ready, out_valid, busy}, s, cout, ovf);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_%0d: got vld=%b busy=%b want 0 0",
                         i, out_valid, busy);
            end
        end
        start_op(16'h0F0F, 16'h00F1, 1'b0);
        wait_done(lat);
        checks++;
        if (lat !== 5 || {s, cout, ovf} !== {16'h1000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL after_reset: got lat=%0d s=%h c=%b o=%b want 5 1000 0 0",
                     lat, s, cout, ovf);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_overflow();
        test_sub();
        test_backpressure();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/adder_seq_ctrl.md
# adder_seq_ctrl

Multi-cycle sequencer that performs a (4·NIBBLES)-bit add or subtract by driving one shared instance of the team's 4-bit carry-lookahead adder (`adder4`), one nibble per clock, least-significant nibble first. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides. It trades latency for area where a full-width adder is not wanted.

## Interface
- NIBBLES, default 4: number of 4-bit slices; operand width W = 4·NIBBLES. Legal range is 2..8.
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operand set presented.
- in_ready  output  1  block accepts operands. High only in IDLE.
- a  input  W  operand A, unsigned or two's-complement.
- b  input  W  operand B.
- sub  input  1  0 selects A+B; 1 selects A−B.
- out_valid  output  1  result registers are valid.
- out_ready  input  1  consumer takes the result.
- s  output  W  sum or difference, modulo 2^W.
- cout  output  1  carry out of the MSB slice. For subtract, 1 means no borrow.
- ovf  output  1  two's-complement overflow.
- busy  output  1  high in RUN or DONE.

## Operation
- States:
  - IDLE: in_ready=1. When in_valid=1, latch a, b and sub; set the nibble index k=0; load the carry register c = sub; go to RUN.
  - RUN: each cycle drives `adder4` with:
    - A = a_reg[4k+3:4k];
    - B = b_reg[4k+3:4k] XOR {4{sub_reg}};
    - C0 = c.
  - RUN register updates, each cycle:
    - write the `adder4` S into s_reg[4k+3:4k];
    - c ← C4;
    - k ← k+1.
  - Leaving RUN: when k = NIBBLES−1, after that cycle's update, capture cout ← C4 and ovf, then go to DONE.
  - DONE: out_valid=1. s, cout and ovf stay stable. When out_ready=1, go to IDLE.
- ovf uses the final slice: ovf = (a_msb == b'_msb) && (s_msb != a_msb), where b' is the inverted B when sub=1.
- No new operands are accepted in DONE. A new transaction starts at the earliest on the cycle after the DONE→IDLE handshake.
- Operand registers are loaded only on the IDLE handshake. Changes on a, b or sub at any other time are ignored.
- s_reg nibbles not yet written in RUN keep their previous value. s is observable as valid only while out_valid=1.
- The counter k is ⌈log2 NIBBLES⌉ bits wide and never wraps past NIBBLES−1.
- Reset (rst_n=0 at a clk edge), from any state including mid-RUN and DONE:
  - state → IDLE;
  - s, cout, ovf, c, k, a_reg, b_reg and sub_reg → 0;
  - the in-flight operation is discarded with no partial out_valid.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, s=0, cout=0, ovf=0.
  - During reset assertion, outputs reflect the reset state from the first edge onward.
- Handshake cycle T0: in_valid·in_ready=1. RUN covers T1..T_NIBBLES. out_valid first asserts in cycle NIBBLES+1.
  - For NIBBLES=4, out_valid rises 5 cycles after the accept edge.
- The output hold cycle is the first cycle with out_valid·out_ready=1; the next cycle is IDLE with in_ready=1.
  - Minimum initiation interval is NIBBLES+2 cycles with out_ready held high.
- All outputs are registered. The only combinational path is in_ready/out_valid, which are decoded from state (no input-to-output paths).
- Carry is registered between slices, so the critical path is one `adder4` plus the B-inversion XOR.

## Test plan
- Add, NIBBLES=4: a=0x1234, b=0x4321, sub=0, out_ready=1 → out_valid in cycle 5, s=0x5555, cout=0, ovf=0. Back-to-back accept 6 cycles after the first.
- Carry ripple across all slices: a=0xFFFF, b=0x0001, add → s=0x0000, cout=1, ovf=0.
- Signed overflow: a=0x7FFF, b=0x0001, add → s=0x8000, cout=0, ovf=1.
- Subtract with borrow: a=0x0005, b=0x0007, sub=1 → s=0xFFFE, cout=0, ovf=0.
- Subtract with overflow: a=0x8000, b=0x0001, sub=1 → s=0x7FFF, cout=1, ovf=1.
- Backpressure and reset:
  - Hold out_ready=0 for 10 cycles in DONE → s, cout and ovf stable, in_ready=0, and an in_valid pulse is ignored.
  - Separately, drop rst_n for one cycle at RUN k=2 → next cycle IDLE, all outputs zero, no out_valid.
  - The following transaction 0x0F0F+0x00F1 yields s=0x1000.
